hub75_src_switch: RTL and testbench
===================================

// Module: hub75_src_switch
// PURPOSE
//  Glitch-free scheduler handing the single HUB75 panel between two HUB75 drivers
//  (src0 = UAH logo, src1 = GIF). Replaces the raw SW0 output mux in the top level.
//  Synchronises and debounces the select switch and changes source only at a row-latch boundary.
//  Blanks the panel (OE high) across every handover so no half-shifted row is ever displayed.
// PARAMETERS
//  DEBOUNCE_CYC  500000  cycles sel_raw must be stable before it is accepted (10 ms @ 50 MHz)
//  BLANK_CYC     64      cycles the panel is held blank between old and new source
//  LAT_TIMEOUT   65536   max cycles to wait for a lat edge before forcing progress
// PORTS
//  clk         in   1   system clock (CLOCK_50 domain)
//  reset_n     in   1   asynchronous active-low reset
//  sel_raw     in   1   unsynchronised slide switch; 0 = src0, 1 = src1
//  s0_bus      in   13  src0 {r1,g1,b1,r2,g2,b2,row_addr[3:0],clk_out,lat,oe}
//  s1_bus      in   13  src1, same packing
//  p_bus       out  13  panel bundle, same packing, registered
//  active_src  out  1   source currently owning the panel
//  busy        out  1   1 while a handover is in progress
//  sw_count    out  8   [HUB75_SW_STATUS_EN only] completed handovers, wraps 255->0
// BEHAVIOUR
//  - Reset: all states below apply immediately on reset_n low, including mid-handover.
//    state=ACTIVE, active_src=0, p_bus data/clk_out/lat=0, row_addr=0, oe=1, busy=0, sw_count=0.
//    Debounced select resets to 0.
//  - sel_raw passes a 2-FF synchroniser. A new level is accepted after DEBOUNCE_CYC consecutive
//    equal samples; any bounce restarts the count.
//  - p_bus is always registered: 1-cycle latency from the selected s*_bus.
//  - FSM:
//    ACTIVE: p_bus <= bus[active_src]. If debounced sel != active_src: tgt <= sel, go to DRAIN.
//    DRAIN:  old source still passed through. On rising lat of old source (lat & ~lat_q) or after
//            LAT_TIMEOUT cycles: go to BLANK.
//    BLANK:  p_bus data=0, clk_out=0, lat=0, oe=1, row_addr held. After BLANK_CYC cycles:
//            active_src <= tgt, go to SYNC.
//    SYNC:   new source's data/clk_out/lat/row passed through, but oe forced to 1. On the first
//            falling lat of the new source, or after LAT_TIMEOUT: go to ACTIVE, oe passes through.
//            sw_count increments on this transition.
//  - busy=1 in DRAIN, BLANK and SYNC.
//  - Select changes during a handover are ignored; tgt is fixed at DRAIN entry. On return to
//    ACTIVE the debounced select is re-evaluated, so a switch flipped back causes a second handover.
//  - Lat edge detectors keep one lat_q per source, updated every cycle regardless of state.
//  - Timeout counter is cleared on every state entry and saturates at LAT_TIMEOUT.
//  - Counters are sized with $clog2 of their parameter, minimum 1 bit.
// CONFIGURATION
//  HUB75_SW_STATUS_EN defined: sw_count port and its 8-bit wrapping counter exist.
//  HUB75_SW_STATUS_EN undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  hub75_pkg holds:
//   - bundle field index constants (R1..OE, ROW_LSB/ROW_MSB) and HUB75_BUS_W=13
//   - typedef sw_state_t {ACTIVE, DRAIN, BLANK, SYNC}
//  Sub-module hub75_sw_debounce (synchroniser + DEBOUNCE_CYC stability counter, outputs sel_db).
//  The FSM, edge detectors and output register live in hub75_src_switch.
// TESTING  (bench params: DEBOUNCE_CYC=8, BLANK_CYC=4, LAT_TIMEOUT=32)
//  1. Reset, both sources toggling -> p_bus oe=1, others 0; one cycle after release, p_bus = s0_bus delayed 1 cycle.
//  2. sel_raw 0->1 bouncing 3 cycles then stable -> DRAIN entered exactly 2+8 cycles after the
//     last edge; busy=1.
//  3. s0 lat pulse 5 cycles into DRAIN -> oe=1 for 4 BLANK cycles; then s1 passes with oe=1 until
//     s1 lat falls; then oe follows s1; active_src=1; sw_count=1.
//  4. s0 lat held 0 during DRAIN -> BLANK entered after 32 cycles; handover still completes.
//  5. sel_raw returned to 0 during BLANK -> handover to s1 completes, then a second handover back
//     to s0; sw_count=2.
//  6. reset_n pulsed low during SYNC -> outputs take reset values asynchronously; active_src=0.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 source switch.
//   - Bit positions of the 13-bit HUB75 bundle
//     {r1,g1,b1,r2,g2,b2,row_addr[3:0],clk_out,lat,oe}
//   - sw_state_t: handover FSM states
//   - hub75_blank(): builds a bundle with the panel blanked and the row held
package hub75_pkg;

  localparam int HUB75_BUS_W = 13;

  localparam int R1      = 12;
  localparam int G1      = 11;
  localparam int B1      = 10;
  localparam int R2      = 9;
  localparam int G2      = 8;
  localparam int B2      = 7;
  localparam int ROW_MSB = 6;
  localparam int ROW_LSB = 3;
  localparam int CLK_OUT = 2;
  localparam int LAT     = 1;
  localparam int OE      = 0;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    BLANK  = 2'd2,
    SYNC   = 2'd3
  } sw_state_t;

  // Colour, shift clock and latch low; output enable high (oe is active low,
  // so the panel is dark). The row address is kept so the panel's row
  // decoder does not see a spurious change.
  function automatic logic [HUB75_BUS_W-1:0] hub75_blank(input logic [3:0] row);
    logic [HUB75_BUS_W-1:0] b;
    b                  = '0;
    b[R1]              = 1'b0;
    b[G1]              = 1'b0;
    b[B1]              = 1'b0;
    b[R2]              = 1'b0;
    b[G2]              = 1'b0;
    b[B2]              = 1'b0;
    b[ROW_MSB:ROW_LSB] = row;
    b[CLK_OUT]         = 1'b0;
    b[LAT]             = 1'b0;
    b[OE]              = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/hub75_sw_debounce.sv
// hub75_sw_debounce: two-flop synchroniser plus stability filter for the
// source-select slide switch.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   sel_raw  in  unsynchronised switch level
//   sel_db   out debounced level (0 after reset)
// A new level is accepted once the synchronised input has differed from the
// accepted level for DEBOUNCE_CYC consecutive samples; any sample equal to
// the accepted level restarts the count. sel_db reflects the acceptance in
// the same cycle the final sample is present, so the consumer reacts on the
// clock edge that completes the count.
module hub75_sw_debounce
  import hub75_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_raw,
  output logic sel_db
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          db_q;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != db_q) && (cnt == CNT_LAST);
  assign sel_db = accept ? sync2 : db_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= sel_raw;
      sync2 <= sync1;
      if (sync2 == db_q) begin
        cnt <= '0;
      end else if (accept) begin
        cnt  <= '0;
        db_q <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hub75_src_switch.sv
// hub75_src_switch: hands one HUB75 panel between two HUB75 drivers
// (src0 = UAH logo, src1 = GIF) without showing a half-shifted row.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   sel_raw     in   raw slide switch, 0 = src0, 1 = src1
//   s0_bus      in   src0 bundle {r1,g1,b1,r2,g2,b2,row[3:0],clk_out,lat,oe}
//   s1_bus      in   src1 bundle, same packing
//   p_bus       out  panel bundle, registered (1-cycle latency)
//   active_src  out  source currently owning the panel
//   busy        out  high while a handover is in progress
//   sw_count    out  completed handovers, 8-bit wrapping
//                    (present only when HUB75_SW_STATUS_EN is defined)
//   dbg_state   out  current handover FSM state
// Handover: ACTIVE -> DRAIN (old source finishes its row, until its lat
// rises or LAT_TIMEOUT) -> BLANK (panel dark for BLANK_CYC cycles, then
// ownership moves) -> SYNC (new source passed with oe forced high until its
// lat falls or LAT_TIMEOUT) -> ACTIVE. The target is frozen on DRAIN entry;
// the switch is re-evaluated once back in ACTIVE.
module hub75_src_switch
  import hub75_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLANK_CYC    = 64,
  parameter int LAT_TIMEOUT  = 65536
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sel_raw,
  input  logic [HUB75_BUS_W-1:0] s0_bus,
  input  logic [HUB75_BUS_W-1:0] s1_bus,
  output logic [HUB75_BUS_W-1:0] p_bus,
  output logic                   active_src,
  output logic                   busy,
`ifdef HUB75_SW_STATUS_EN
  output logic [7:0]             sw_count,
`endif
  output sw_state_t              dbg_state
);

  localparam int TW = (LAT_TIMEOUT > 1) ? $clog2(LAT_TIMEOUT) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(LAT_TIMEOUT - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  sw_state_t              state;
  sw_state_t              state_nx;
  logic                   sel_db;
  logic                   tgt;
  logic [1:0]             lat_q;
  logic [TW-1:0]          tmo_cnt;
  logic [BW-1:0]          blank_cnt;
  logic [HUB75_BUS_W-1:0] cur_bus;
  logic [HUB75_BUS_W-1:0] p_nx;
  logic                   lat_rise;
  logic                   lat_fall;
  logic                   tmo_done;
  logic                   blank_done;
  logic                   take_tgt;
  logic                   switch_done;

  hub75_sw_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .sel_raw (sel_raw),
    .sel_db  (sel_db)
  );

  // Everything the panel sees comes from the current owner; during DRAIN
  // that is the old source, during SYNC already the new one.
  assign cur_bus    = active_src ? s1_bus : s0_bus;
  assign lat_rise   = cur_bus[LAT] & ~lat_q[active_src];
  assign lat_fall   = ~cur_bus[LAT] & lat_q[active_src];
  assign tmo_done   = (tmo_cnt == TMO_LAST);
  assign blank_done = (blank_cnt == BLANK_LAST);

  assign busy      = (state != ACTIVE);
  assign dbg_state = state;

  always_comb begin
    state_nx    = state;
    p_nx        = cur_bus;
    take_tgt    = 1'b0;
    switch_done = 1'b0;
    case (state)
      ACTIVE: begin
        if (sel_db != active_src) state_nx = DRAIN;
      end
      DRAIN: begin
        if (lat_rise || tmo_done) state_nx = BLANK;
      end
      BLANK: begin
        p_nx = hub75_blank(p_bus[ROW_MSB:ROW_LSB]);
        if (blank_done) begin
          state_nx = SYNC;
          take_tgt = 1'b1;
        end
      end
      SYNC: begin
        // New source may be mid-row; keep the panel dark until it latches.
        p_nx[OE] = 1'b1;
        if (lat_fall || tmo_done) begin
          state_nx    = ACTIVE;
          switch_done = 1'b1;
        end
      end
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ACTIVE;
      p_bus      <= hub75_blank(4'd0);
      active_src <= 1'b0;
      tgt        <= 1'b0;
      lat_q      <= 2'b00;
      tmo_cnt    <= '0;
      blank_cnt  <= '0;
    end else begin
      state <= state_nx;
      p_bus <= p_nx;
      lat_q <= {s1_bus[LAT], s0_bus[LAT]};
      if ((state == ACTIVE) && (state_nx == DRAIN)) tgt <= sel_db;
      if (take_tgt) active_src <= tgt;
      // Both counters restart on every state change.
      if (state_nx != state) begin
        tmo_cnt   <= '0;
        blank_cnt <= '0;
      end else begin
        if (!tmo_done) tmo_cnt <= tmo_cnt + TW'(1);
        if ((state == BLANK) && !blank_done) blank_cnt <= blank_cnt + BW'(1);
      end
    end
  end

`ifdef HUB75_SW_STATUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_count <= 8'd0;
    end else if (switch_done) begin
      sw_count <= sw_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hub75_src_switch.sv
`timescale 1ns/1ps
module tb_hub75_src_switch;
  import hub75_pkg::*;

  localparam int DEB = 8;
  localparam int BLK = 4;
  localparam int TMO = 32;

  localparam int P_ACT = 0;
  localparam int P_DRN = 1;
  localparam int P_BLK = 2;
  localparam int P_SYN = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel_raw;
  logic [12:0] s0_bus = '0;
  logic [12:0] s1_bus = '0;
  logic [12:0] p_bus;
  logic        active_src;
  logic        busy;
  sw_state_t   dbg_state;
`ifdef HUB75_SW_STATUS_EN
  logic [7:0]  sw_count;
`endif

  always #5 clk = ~clk;

  hub75_src_switch #(
    .DEBOUNCE_CYC(DEB),
    .BLANK_CYC   (BLK),
    .LAT_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sel_raw    (sel_raw),
    .s0_bus     (s0_bus),
    .s1_bus     (s1_bus),
    .p_bus      (p_bus),
    .active_src (active_src),
    .busy       (busy),
`ifdef HUB75_SW_STATUS_EN
    .sw_count   (sw_count),
`endif
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source drivers ----------------
  // lat of each source is either random or forced, colour/row/clk/oe random.
  bit lat_mode [2];
  bit lat_force[2];

  function automatic logic [12:0] mk_bus(input int i);
    logic [12:0] b;
    b      = 13'($urandom);
    b[LAT] = lat_mode[i] ? ($urandom_range(0, 3) == 0) : lat_force[i];
    return b;
  endfunction

  always @(negedge clk) begin
    s0_bus = mk_bus(0);
    s1_bus = mk_bus(1);
  end

  // ---------------- behavioural model ----------------
  int          m_phase;
  int          m_age;
  int          m_count;
  bit          m_src;
  bit          m_tgt;
  bit          m_db;
  logic [12:0] m_p;
  bit          m_lat_prev[2];
  bit          raw_q[$];

  task automatic model_reset();
    m_phase = P_ACT;
    m_age   = 0;
    m_count = 0;
    m_src   = 1'b0;
    m_tgt   = 1'b0;
    m_db    = 1'b0;
    m_p     = 13'h001;
    m_lat_prev[0] = 1'b0;
    m_lat_prev[1] = 1'b0;
    raw_q.delete();
    repeat (10) raw_q.push_back(1'b0);
  endtask

  // One clock edge. raw_q holds the switch level sampled at the last 10
  // edges; the level seen after the 2-stage synchroniser at this edge is the
  // one sampled 2 edges ago, so the last DEB synchronised samples are
  // raw_q[0..DEB-1].
  task automatic model_step();
    logic [12:0] cur;
    logic [3:0]  row;
    bit          lat_now, lat_was, stable, leave;
    raw_q.push_back(sel_raw);
    void'(raw_q.pop_front());
    stable = 1'b1;
    for (int i = 1; i < DEB; i++) if (raw_q[i] != raw_q[0]) stable = 1'b0;
    if (stable && (raw_q[0] != m_db)) m_db = raw_q[0];

    cur     = m_src ? s1_bus : s0_bus;
    lat_now = cur[LAT];
    lat_was = m_lat_prev[m_src];

    if (m_phase == P_BLK) begin
      row = m_p[6:3];
      m_p = {6'b0, row, 3'b001};
    end else if (m_phase == P_SYN) begin
      m_p = cur | 13'h001;
    end else begin
      m_p = cur;
    end

    leave = 1'b0;
    case (m_phase)
      P_ACT: if (m_db != m_src) begin m_tgt = m_db; leave = 1'b1; end
      P_DRN: leave = (lat_now && !lat_was) || (m_age + 1 >= TMO);
      P_BLK: if (m_age + 1 >= BLK) begin leave = 1'b1; m_src = m_tgt; end
      default: if ((!lat_now && lat_was) || (m_age + 1 >= TMO)) begin
        leave = 1'b1;
        m_count++;
      end
    endcase
    if (leave) begin
      m_phase = (m_phase + 1) % 4;
      m_age   = 0;
    end else begin
      m_age++;
    end
    m_lat_prev[0] = s0_bus[LAT];
    m_lat_prev[1] = s1_bus[LAT];
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always begin
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    chk("p_bus", p_bus, m_p);
    chk("active_src", active_src, m_src);
    chk("busy", busy, (m_phase != P_ACT));
    chk("state", dbg_state, m_phase);
`ifdef HUB75_SW_STATUS_EN
    chk("sw_count", sw_count, m_count[7:0]);
`endif
  end

  // ---------------- helpers ----------------
  task automatic wait_state(input sw_state_t s, input int max, input string name);
    int n;
    n = 0;
    while ((dbg_state != s) && (n < max)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (dbg_state != s) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: timeout, state %0d required %0d", name, dbg_state, s);
    end
  endtask

  task automatic count_state(input sw_state_t s, output int n);
    n = 0;
    while ((dbg_state == s) && (n < 200)) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_values(input string name);
    chk({name, "_p_bus"}, p_bus, 13'h001);
    chk({name, "_active"}, active_src, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_state"}, dbg_state, ACTIVE);
`ifdef HUB75_SW_STATUS_EN
    chk({name, "_swcnt"}, sw_count, 8'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [12:0] v;
    int          n;
    lat_mode[0] = 1'b1;
    lat_mode[1] = 1'b1;
    lat_force[0] = 1'b0;
    lat_force[1] = 1'b0;
    sel_raw = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // 1. reset with both sources toggling
    repeat (4) @(posedge clk);
    #1 chk_reset_values("reset");
    #1 reset_n = 1'b1;
    @(posedge clk);
    v = s0_bus;
    #1 chk("first_pass", p_bus, v);
    repeat (30) @(posedge clk);

    // 2. bouncing switch, then stable
    #2;
    lat_mode[0] = 1'b0;
    lat_mode[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 sel_raw = 1'b1;
    @(posedge clk); #2 sel_raw = 1'b0;
    @(posedge clk); #2 sel_raw = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!busy && (n < 40));
    chk("drain_latency", n, 10);
    chk("drain_state", dbg_state, DRAIN);

    // 3. s0 lat pulse 5 cycles into DRAIN
    repeat (4) @(posedge clk);
    #2 lat_force[0] = 1'b1;
    @(posedge clk);
    #2 lat_force[0] = 1'b0;
    count_state(BLANK, n);
    chk("blank_len", n, BLK);
    chk("sync_entered", dbg_state, SYNC);
    @(posedge clk);
    v = s1_bus;
    #1 chk("sync_oe_forced", p_bus, v | 13'h001);
    #1 lat_force[1] = 1'b1;
    @(posedge clk);
    #2 lat_force[1] = 1'b0;
    @(posedge clk);
    #1 chk("h1_busy", busy, 1'b0);
    chk("h1_active", active_src, 1'b1);
    @(posedge clk);
    v = s1_bus;
    #1 chk("oe_follows", p_bus, v);
    chk("h1_count_model", m_count, 1);
`ifdef HUB75_SW_STATUS_EN
    chk("h1_sw_count", sw_count, 8'd1);
`endif

    // 4. no lat edges at all: both waits end on the timeout
    #1 sel_raw = 1'b0;
    wait_state(DRAIN, 40, "t4_drain");
    count_state(DRAIN, n);
    chk("drain_timeout_len", n, TMO);
    count_state(BLANK, n);
    chk("blank_len2", n, BLK);
    count_state(SYNC, n);
    chk("sync_timeout_len", n, TMO);
    chk("h2_active", active_src, 1'b0);
    chk("h2_busy", busy, 1'b0);

    // reset between scenarios
    #1 reset_n = 1'b0;
    #1 chk_reset_values("mid_reset");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // 5. switch flipped back during BLANK -> two handovers
    lat_mode[0] = 1'b1;
    lat_mode[1] = 1'b1;
    @(posedge clk);
    #2 sel_raw = 1'b1;
    wait_state(BLANK, 100, "t5_blank");
    #1 sel_raw = 1'b0;
    wait_state(ACTIVE, 100, "t5_active1");
    chk("t5_first_src", active_src, 1'b1);
    wait_state(DRAIN, 60, "t5_drain2");
    wait_state(ACTIVE, 100, "t5_active2");
    chk("t5_back_src", active_src, 1'b0);
    chk("t5_count_model", m_count, 2);
`ifdef HUB75_SW_STATUS_EN
    chk("t5_sw_count", sw_count, 8'd2);
`endif

    // random switching with random lat activity
    repeat (40) begin
      @(posedge clk);
      #2 sel_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) @(posedge clk);
    end

    // 6. reset pulse in SYNC
    wait_state(ACTIVE, 200, "t6_idle");
    #1;
    lat_mode[0] = 1'b0;
    lat_mode[1] = 1'b0;
    lat_force[0] = 1'b0;
    lat_force[1] = 1'b0;
    sel_raw = ~m_src;
    wait_state(SYNC, 150, "t6_sync");
    repeat (2) @(posedge clk);
    #2 chk("t6_pre_sync", dbg_state, SYNC);
    reset_n = 1'b0;
    #1 chk_reset_values("async_reset");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
